// File: rtl/pwm_fade_sequencer.sv
// Breathing-LED sequencer: ramps a pwm threshold up, holds, ramps down, holds, repeats.
// Optional GAMMA_EN: threshold follows an approximate gamma-2 curve of level instead of level itself.
module pwm_fade_sequencer #(
  parameter int unsigned PRESCALE   = 12000,
  parameter int unsigned PWM_MAX    = 255,
  parameter int unsigned HOLD_TICKS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] step,
  output logic [7:0] threshold,
  output logic [7:0] max,
  output logic [7:0] level,
  output logic [2:0] phase,
  output logic       cycle_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [8:0]    MAX9      = 9'(PWM_MAX);

  state_t        state, state_nx;
  logic [PW-1:0] pre_cnt;
  logic [HW-1:0] hold, hold_nx;
  logic [7:0]    level_nx, threshold_nx, step_eff;
  logic [8:0]    sum;
  logic          tick, hold_last;

  assign max   = MAX9[7:0];
  assign phase = state;
  assign tick  = (state != IDLE) && (pre_cnt == PRE_LAST);

`ifdef GAMMA_EN
  assign threshold_nx = 8'(({8'd0, level} * ({8'd0, level} + 16'd1)) >> 8);
`else
  assign threshold_nx = level;
`endif

  // NOTE: every signal driven here gets a default before the case, so no path can infer a latch.
  always_comb begin
    step_eff   = (step == 8'd0) ? 8'd1 : step;
    sum        = {1'b0, level} + {1'b0, step_eff};
    hold_last  = (hold == HOLD_LAST);
    state_nx   = state;
    level_nx   = level;
    hold_nx    = hold;
    cycle_done = 1'b0;
    case (state)
      IDLE: begin
        level_nx = '0;
        hold_nx  = '0;
        if (enable) state_nx = UP;
      end
      UP: begin
        if (!enable) begin
          state_nx = DOWN;
          hold_nx  = '0;
        end else if (tick) begin
          if (sum >= MAX9) begin
            level_nx = MAX9[7:0];
            state_nx = HOLD_HI;
            hold_nx  = '0;
          end else begin
            level_nx = sum[7:0];
          end
        end
      end
      HOLD_HI: begin
        if (!enable || (tick && hold_last)) begin
          state_nx = DOWN;
          hold_nx  = '0;
        end else if (tick) begin
          hold_nx = hold + HW'(1);
        end
      end
      DOWN: begin
        if (tick) begin
          if (level <= step_eff) begin
            level_nx = '0;
            state_nx = HOLD_LO;
            hold_nx  = '0;
          end else begin
            level_nx = level - step_eff;
          end
        end
      end
      HOLD_LO: begin
        // Dropping enable here abandons the breath, so it never reports completion.
        if (!enable) begin
          state_nx = IDLE;
          hold_nx  = '0;
        end else if (tick && hold_last) begin
          cycle_done = 1'b1;
          state_nx   = UP;
          hold_nx    = '0;
        end else if (tick) begin
          hold_nx = hold + HW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        level_nx = '0;
        hold_nx  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      level     <= '0;
      threshold <= '0;
      hold      <= '0;
      pre_cnt   <= '0;
    end else begin
      state     <= state_nx;
      level     <= level_nx;
      threshold <= threshold_nx;
      hold      <= hold_nx;
      // Prescaler is parked at zero in IDLE, so a new run gets a full first tick period.
      if (state == IDLE || state_nx == IDLE || tick) pre_cnt <= '0;
      else                                            pre_cnt <= pre_cnt + PW'(1);
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: a tick-level reference model queues expected outputs
// each clock, and an independent monitor pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_pwm_fade_sequencer;

  localparam int PRESCALE   = 4;
  localparam int PWM_MAX    = 255;
  localparam int HOLD_TICKS = 2;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [7:0] step;
  logic [7:0] threshold, max, level;
  logic [2:0] phase;
  logic       cycle_done;

  always #5 clk = ~clk;

  pwm_fade_sequencer #(
    .PRESCALE  (PRESCALE),
    .PWM_MAX   (PWM_MAX),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .step      (step),
    .threshold (threshold),
    .max       (max),
    .level     (level),
    .phase     (phase),
    .cycle_done(cycle_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: phase codes and brightness in plain integers; ticks derived from clocks
  // elapsed since the sequence left IDLE.
  int m_phase, m_level, m_thr, m_run, m_hold_ticks;

  function automatic int gamma_of(input int l);
`ifdef GAMMA_EN
    return (l * (l + 1)) / 256;
`else
    return l;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_level = 0; m_thr = 0; m_run = 0; m_hold_ticks = 0;
  endtask

  task automatic model_step(input bit en, input int s, output bit cd);
    bit tick;
    int st, np, nl;
    tick = (m_phase != 0) && ((m_run % PRESCALE) == PRESCALE - 1);
    st   = (s == 0) ? 1 : s;
    np   = m_phase;
    nl   = m_level;
    cd   = 1'b0;
    case (m_phase)
      0: begin nl = 0; if (en) np = 1; end
      1: if (!en) np = 3;
         else if (tick) begin
           if (m_level + st >= PWM_MAX) begin nl = PWM_MAX; np = 2; end
           else nl = m_level + st;
         end
      2: if (!en) np = 3;
         else if (tick) begin
           m_hold_ticks++;
           if (m_hold_ticks == HOLD_TICKS) np = 3;
         end
      3: if (tick) begin
           if (m_level <= st) begin nl = 0; np = 4; end
           else nl = m_level - st;
         end
      4: if (!en) np = 0;
         else if (tick) begin
           m_hold_ticks++;
           if (m_hold_ticks == HOLD_TICKS) begin cd = 1'b1; np = 1; end
         end
      default: np = 0;
    endcase
    if (np != m_phase) m_hold_ticks = 0;
    m_run   = (m_phase != 0 && np != 0) ? m_run + 1 : 0;
    m_thr   = gamma_of(m_level);
    m_level = nl;
    m_phase = np;
  endtask

  typedef struct packed {
    logic [2:0] ph;
    logic [7:0] lv;
    logic [7:0] th;
    logic       cd;
  } obs_t;

  obs_t exp_q[$];
  int   stage_q[$];
  int   lvl_q[$];
  int   stage;

  // One clock of stimulus: drive inputs just after the edge, queue what the DUT must show now.
  task automatic drive(input bit rst, input bit en, input int s);
    obs_t o;
    bit   cd;
    @(posedge clk);
    #1;
    reset  = rst;
    enable = en;
    step   = 8'(s);
    if (rst) begin
      model_reset();
      cd = 1'b0;
    end
    o.ph = 3'(m_phase);
    o.lv = 8'(m_level);
    o.th = 8'(m_thr);
    if (!rst) model_step(en, s, cd);
    o.cd = cd;
    exp_q.push_back(o);
    stage_q.push_back(stage);
  endtask

  initial begin
    obs_t       e;
    int         sg;
    logic [7:0] last_lvl;
    last_lvl = 8'd0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        sg = stage_q.pop_front();
        check($sformatf("stage%0d max/phase/level/thr/cd", sg),
              {4'd0, max, phase, level, threshold, cycle_done},
              {4'd0, 8'(PWM_MAX), e.ph, e.lv, e.th, e.cd});
        if (level !== last_lvl && lvl_q.size() > 0)
          check("first_breath_level", {24'd0, level}, 32'(lvl_q.pop_front()));
        last_lvl = level;
      end
    end
  end

  initial begin
    bit cur_en;
    int cur_step;
    reset = 1'b0; enable = 1'b0; step = 8'd0;
    model_reset();
    lvl_q = '{64, 128, 192, 255, 191, 127, 63, 0};

    stage = 0;
    repeat (3) drive(1'b1, 1'b1, 64);

    stage = 1;
    repeat (60) drive(1'b0, 1'b1, 64);

    stage = 2;
    repeat (40) drive(1'b0, 1'b1, 0);

    stage = 3;
    drive(1'b1, 1'b1, 64);
    for (int i = 0; i < 200 && !(m_phase == 1 && m_level == 128); i++) drive(1'b0, 1'b1, 64);
    repeat (80) drive(1'b0, 1'b0, 64);

    stage = 4;
    cur_en   = 1'b1;
    cur_step = 32;
    for (int i = 0; i < 15000 && errors < 20; i++) begin
      if ($urandom_range(0, 149) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 19) == 0)
        cur_step = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      drive($urandom_range(0, 3999) == 0, cur_en, cur_step);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
